// File: rtl/zx_cmd_port_if.sv
// Z80 I/O bus and SD-loader command handshake signals for zx_cmd_port.
// The slave modport is the command port itself; the master side is the
// Z80 bus plus the SD loader that answers the handshake.
interface zx_cmd_port_if;
    logic [15:0] z80_addr;
    logic [7:0]  z80_data_in;
    logic [7:0]  z80_data_out;
    logic        z80_data_oe;
    logic        z80_iorq_n;
    logic        z80_rd_n;
    logic        z80_wr_n;
    logic        z80_m1_n;
    logic [7:0]  cpu_cmd;
    logic [15:0] cpu_address;
    logic        cpu_cmd_en;
    logic        cpu_cmd_ack;
    logic        busy;

    modport slave (
        input  z80_addr,
        input  z80_data_in,
        output z80_data_out,
        output z80_data_oe,
        input  z80_iorq_n,
        input  z80_rd_n,
        input  z80_wr_n,
        input  z80_m1_n,
        output cpu_cmd,
        output cpu_address,
        output cpu_cmd_en,
        input  cpu_cmd_ack,
        output busy
    );

    modport master (
        output z80_addr,
        output z80_data_in,
        input  z80_data_out,
        input  z80_data_oe,
        output z80_iorq_n,
        output z80_rd_n,
        output z80_wr_n,
        output z80_m1_n,
        input  cpu_cmd,
        input  cpu_address,
        input  cpu_cmd_en,
        output cpu_cmd_ack,
        input  busy
    );
endinterface

// File: rtl/zx_cmd_port.sv
// Z80 command port: an OUT to CMD_PORT latches a command byte and address
// and hands it to the SD loader with a four-phase en/ack handshake.
// An IN from CMD_PORT returns {busy, err, overrun, 5'b0}; the flags clear
// when that IN finishes.
module zx_cmd_port #(
    parameter logic [7:0]  CMD_PORT    = 8'hEB,
    parameter logic [23:0] ACK_TIMEOUT = 24'd5_000_000
) (
    input  logic          clk_50,
    input  logic          reset,
    zx_cmd_port_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // strobe vector order: {m1_n, wr_n, rd_n, iorq_n}
    logic [3:0]  strobe_raw;
    logic [3:0]  strobe_meta_q, strobe_meta_d;
    logic [3:0]  strobe_sync_q, strobe_sync_d;
    logic        ack_meta_q, ack_meta_d;
    logic        ack_sync_q, ack_sync_d;

    logic        iorq_s, rd_s, wr_s, m1_s;
    logic        port_match;
    logic        wr_hit, rd_hit;
    logic        wr_hit_q, wr_hit_d;
    logic        rd_hit_q, rd_hit_d;
    logic        wr_event, rd_end;

    logic [23:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] address_q, address_d;
    logic        cmd_en_q, cmd_en_d;
    logic        err_q, err_d;
    logic        overrun_q, overrun_d;
    logic        err_set, ovr_set;
    logic        busy;
    logic [7:0]  data_out_q, data_out_d;

    assign strobe_raw = {bus.z80_m1_n, bus.z80_wr_n, bus.z80_rd_n, bus.z80_iorq_n};

    assign iorq_s = strobe_sync_q[0];
    assign rd_s   = strobe_sync_q[1];
    assign wr_s   = strobe_sync_q[2];
    assign m1_s   = strobe_sync_q[3];

    // The address is held stable by the Z80 for the whole I/O cycle, so it
    // is qualified directly by the synchronised strobes.
    assign port_match = (bus.z80_addr[7:0] == CMD_PORT);
    assign wr_hit     = !iorq_s && !wr_s && m1_s && port_match;
    assign rd_hit     = !iorq_s && !rd_s && m1_s && port_match;
    assign wr_event   = wr_hit && !wr_hit_q;
    assign rd_end     = !rd_hit && rd_hit_q;

    assign busy    = (state_q != ST_IDLE);
    assign cnt_inc = cnt_q + 24'd1;

    // Synchroniser and edge-detector next values.
    always_comb begin
        strobe_meta_d = strobe_raw;
        strobe_sync_d = strobe_meta_q;
        ack_meta_d    = bus.cpu_cmd_ack;
        ack_sync_d    = ack_meta_q;
        wr_hit_d      = wr_hit;
        rd_hit_d      = rd_hit;
    end

    // Synchroniser flops reset to the idle bus level so release of reset
    // never looks like the start or end of a cycle.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            strobe_meta_q <= 4'b1111;
            strobe_sync_q <= 4'b1111;
            ack_meta_q    <= 1'b0;
            ack_sync_q    <= 1'b0;
            wr_hit_q      <= 1'b0;
            rd_hit_q      <= 1'b0;
        end else begin
            strobe_meta_q <= strobe_meta_d;
            strobe_sync_q <= strobe_sync_d;
            ack_meta_q    <= ack_meta_d;
            ack_sync_q    <= ack_sync_d;
            wr_hit_q      <= wr_hit_d;
            rd_hit_q      <= rd_hit_d;
        end
    end

    // Handshake FSM, timeout counter and status flags.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        address_d  = address_q;
        cmd_en_d   = cmd_en_q;
        err_d      = err_q;
        overrun_d  = overrun_q;
        err_set    = 1'b0;
        ovr_set    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_en_d = 1'b0;
                cnt_d    = 24'd0;
                if (wr_event) begin
                    cmd_d     = bus.z80_data_in;
                    address_d = bus.z80_addr;
                    cmd_en_d  = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                if (ack_sync_q) begin
                    cmd_en_d = 1'b0;
                    cnt_d    = 24'd0;
                    state_d  = ST_REL;
                end else if (cnt_inc == ACK_TIMEOUT) begin
                    err_set  = 1'b1;
                    cmd_en_d = 1'b0;
                    cnt_d    = 24'd0;
                    state_d  = ST_IDLE;
                end
            end
            ST_REL: begin
                cmd_en_d = 1'b0;
                cnt_d    = cnt_inc;
                if (!ack_sync_q) begin
                    cnt_d   = 24'd0;
                    state_d = ST_IDLE;
                end else if (cnt_inc == ACK_TIMEOUT) begin
                    err_set = 1'b1;
                    cnt_d   = 24'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cmd_en_d = 1'b0;
                cnt_d    = 24'd0;
                state_d  = ST_IDLE;
            end
        endcase

        // A second OUT during a handshake is discarded and remembered.
        if (wr_event && busy) begin
            ovr_set = 1'b1;
        end

        // Clear first, then set, so a flag raised in the same cycle survives.
        if (rd_end) begin
            err_d     = 1'b0;
            overrun_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
        if (ovr_set) begin
            overrun_d = 1'b1;
        end

        data_out_d = {busy, err_q, overrun_q, 5'b00000};
    end

    // Control and status registers; reset drops cpu_cmd_en immediately.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 24'd0;
            cmd_q      <= 8'd0;
            address_q  <= 16'd0;
            cmd_en_q   <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
            data_out_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            address_q  <= address_d;
            cmd_en_q   <= cmd_en_d;
            err_q      <= err_d;
            overrun_q  <= overrun_d;
            data_out_q <= data_out_d;
        end
    end

    // Read enable comes straight from the pins so the Z80 sees data in time.
    assign bus.z80_data_oe  = !bus.z80_iorq_n && !bus.z80_rd_n && bus.z80_m1_n &&
                              (bus.z80_addr[7:0] == CMD_PORT);
    assign bus.z80_data_out = data_out_q;
    assign bus.cpu_cmd      = cmd_q;
    assign bus.cpu_address  = address_q;
    assign bus.cpu_cmd_en   = cmd_en_q;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_zx_cmd_port.sv
// Scoreboard bench for zx_cmd_port: Z80 bus cycles and an SD-loader
// responder are driven here; expected commands and status bytes are queued
// by the stimulus and compared by a monitor when the DUT presents them.
module tb_zx_cmd_port;
    localparam logic [7:0] PORT = 8'hEB;
    localparam int         TMO  = 100;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } cmd_exp_t;

    logic clk_50 = 1'b0;
    logic reset  = 1'b1;
    zx_cmd_port_if bus();

    zx_cmd_port #(.CMD_PORT(PORT), .ACK_TIMEOUT(24'(TMO))) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_50 = ~clk_50;

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_exp_t   cmd_q[$];
    logic [7:0] stat_q[$];

    // reference model state
    logic       m_err = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_last_cmd = 8'h00;

    // responder controls
    int  ack_delay   = 5;
    int  ack_hold    = 4;
    bit  resp_enable = 1'b1;
    int  rs          = 0;
    int  rise_cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected commands on cpu_cmd_en rise and expected
    // status bytes at the end of each data_oe window.
    initial begin
        logic       prev_en = 1'b0;
        logic       prev_oe = 1'b0;
        logic [7:0] last_dout = 8'h00;
        cmd_exp_t   e;
        logic [7:0] s;
        forever begin
            @(negedge clk_50);
            if (bus.cpu_cmd_en && !prev_en) begin
                rise_cyc = cyc;
                if (cmd_q.size() == 0) begin
                    check("unexpected_cmd_en", 32'd1, 32'd0);
                end else begin
                    e = cmd_q.pop_front();
                    check("cpu_cmd", {24'd0, bus.cpu_cmd}, {24'd0, e.data});
                    check("cpu_address", {16'd0, bus.cpu_address}, {16'd0, e.addr});
                    check("en_latency", cyc, e.cyc);
                    $display("cmd   addr=%04h data=%02h at cycle %0d", bus.cpu_address, bus.cpu_cmd, cyc);
                end
            end
            prev_en = bus.cpu_cmd_en;
            if (bus.z80_data_oe) last_dout = bus.z80_data_out;
            if (!bus.z80_data_oe && prev_oe) begin
                if (stat_q.size() == 0) begin
                    check("unexpected_data_oe", 32'd1, 32'd0);
                end else begin
                    s = stat_q.pop_front();
                    check("status", {24'd0, last_dout}, {24'd0, s});
                    $display("in    status=%02h expected=%02h", last_dout, s);
                end
            end
            prev_oe = bus.z80_data_oe;
        end
    end

    // SD-loader responder: raises ack ack_delay cycles after cpu_cmd_en,
    // drops it ack_hold cycles after raising; checks en/busy reaction times.
    initial begin
        int cnt;
        bit fell;
        bus.cpu_cmd_ack = 1'b0;
        forever begin
            @(negedge clk_50);
            if (reset) begin
                bus.cpu_cmd_ack = 1'b0;
                rs = 0;
            end else begin
                case (rs)
                    0: if (bus.cpu_cmd_en && resp_enable) begin cnt = 0; rs = 1; end
                    1: begin
                        cnt++;
                        if (cnt >= ack_delay) begin
                            bus.cpu_cmd_ack = 1'b1;
                            cnt = 0; fell = 1'b0; rs = 2;
                        end
                    end
                    2: begin
                        cnt++;
                        if (!fell && !bus.cpu_cmd_en) begin
                            check("en_drop_after_ack", cnt, 3);
                            fell = 1'b1;
                        end
                        if ((fell && cnt >= ack_hold) || cnt > 60) begin
                            if (!fell) check("en_drop_timeout", 32'd1, 32'd0);
                            bus.cpu_cmd_ack = 1'b0;
                            cnt = 0; rs = 3;
                        end
                    end
                    3: begin
                        cnt++;
                        if (!bus.busy) begin
                            check("busy_drop_after_ack", cnt, 3);
                            rs = 0;
                        end else if (cnt > 60) begin
                            check("busy_drop_timeout", 32'd1, 32'd0);
                            rs = 0;
                        end
                    end
                    default: rs = 0;
                endcase
            end
        end
    end

    task automatic bus_idle();
        bus.z80_iorq_n = 1'b1;
        bus.z80_rd_n   = 1'b1;
        bus.z80_wr_n   = 1'b1;
        bus.z80_m1_n   = 1'b1;
    endtask

    // OUT cycle; accepted=1 means the model expects a new command.
    task automatic z80_out(input logic [15:0] addr, input logic [7:0] data, input bit accepted);
        cmd_exp_t e;
        @(negedge clk_50);
        if (accepted) begin
            e.addr = addr; e.data = data; e.cyc = cyc + 3;
            cmd_q.push_back(e);
            m_last_cmd = data;
        end
        $display("out   addr=%04h data=%02h accepted=%0d", addr, data, accepted);
        bus.z80_addr = addr; bus.z80_data_in = data;
        bus.z80_iorq_n = 1'b0; bus.z80_wr_n = 1'b0;
        repeat (4) @(negedge clk_50);
        bus_idle();
        repeat (3) @(negedge clk_50);
    endtask

    // IN cycle; a hit on the command port returns the model status byte.
    task automatic z80_in(input logic [15:0] addr, input bit busy_now);
        bit hit;
        hit = (addr[7:0] == PORT);
        @(negedge clk_50);
        if (hit) begin
            stat_q.push_back({busy_now, m_err, m_ovr, 5'b00000});
            m_err = 1'b0; m_ovr = 1'b0;
        end
        bus.z80_addr = addr;
        bus.z80_iorq_n = 1'b0; bus.z80_rd_n = 1'b0;
        repeat (2) @(negedge clk_50);
        check("data_oe_in", {31'd0, bus.z80_data_oe}, {31'd0, hit});
        repeat (2) @(negedge clk_50);
        bus_idle();
        repeat (4) @(negedge clk_50);
    endtask

    // Interrupt-acknowledge cycle: must be invisible to the port.
    task automatic z80_inta(input logic [15:0] addr);
        @(negedge clk_50);
        $display("inta  addr=%04h", addr);
        bus.z80_addr = addr;
        bus.z80_iorq_n = 1'b0; bus.z80_m1_n = 1'b0;
        repeat (3) @(negedge clk_50);
        check("data_oe_inta", {31'd0, bus.z80_data_oe}, 32'd0);
        @(negedge clk_50);
        bus_idle();
        repeat (3) @(negedge clk_50);
        check("inta_no_en", {31'd0, bus.cpu_cmd_en}, 32'd0);
        check("inta_no_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || rs != 0 || bus.cpu_cmd_ack) && n < 400) begin
            @(negedge clk_50);
            n++;
        end
        if (n >= 400) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cmd_en"}, {31'd0, bus.cpu_cmd_en}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_cmd"}, {24'd0, bus.cpu_cmd}, 32'd0);
        check({tag, "_addr"}, {16'd0, bus.cpu_address}, 32'd0);
        check({tag, "_dout"}, {24'd0, bus.z80_data_out}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  lo, d1, d2;
        logic [15:0] a1;
        int          kind, n;

        bus_idle();
        bus.z80_addr = 16'h0000;
        bus.z80_data_in = 8'h00;
        repeat (4) @(negedge clk_50);
        check_outputs_zero("reset");
        check("reset_oe", {31'd0, bus.z80_data_oe}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk_50);
        check_outputs_zero("post_reset");

        // Basic handshake: ack 10 cycles after en, dropped 5 cycles later.
        ack_delay = 10; ack_hold = 5;
        z80_out(16'h12EB, 8'h05, 1'b1);
        wait_idle();
        check("basic_cmd_held", {24'd0, bus.cpu_cmd}, 32'h05);

        // Overrun: second OUT during REQ is dropped, status read while busy.
        ack_delay = 40; ack_hold = 4;
        z80_out(16'h00EB, 8'h05, 1'b1);
        z80_out(16'h00EB, 8'h07, 1'b0);
        m_ovr = 1'b1;
        check("overrun_cmd_kept", {24'd0, bus.cpu_cmd}, {24'd0, m_last_cmd});
        z80_in(16'h00EB, 1'b1);
        wait_idle();
        z80_in(16'h00EB, 1'b0);

        // Timeout: loader never answers.
        resp_enable = 1'b0;
        z80_out(16'h34EB, 8'hA5, 1'b1);
        n = 0;
        while (bus.cpu_cmd_en && n < 300) begin
            @(negedge clk_50);
            n++;
        end
        check("timeout_en_width", cyc - rise_cyc, TMO);
        check("timeout_idle", {31'd0, bus.busy}, 32'd0);
        m_err = 1'b1;
        resp_enable = 1'b1;
        z80_in(16'h00EB, 1'b0);
        z80_in(16'h00EB, 1'b0);

        // Wrong port and interrupt acknowledge.
        z80_out(16'h00EA, 8'h55, 1'b0);
        check("wrong_port_no_busy", {31'd0, bus.busy}, 32'd0);
        z80_in(16'h00EA, 1'b0);
        z80_inta(16'h00EB);

        // Reset in the middle of REQ.
        ack_delay = 40;
        z80_out(16'h77EB, 8'h33, 1'b1);
        check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1 check_outputs_zero("mid_reset");
        m_err = 1'b0; m_ovr = 1'b0; m_last_cmd = 8'h00;
        repeat (3) @(negedge clk_50);
        reset = 1'b0;
        repeat (3) @(negedge clk_50);
        check("after_reset_no_en", {31'd0, bus.cpu_cmd_en}, 32'd0);
        ack_delay = 6; ack_hold = 4;
        z80_out(16'h09EB, 8'h09, 1'b1);
        wait_idle();
        check("after_reset_cmd", {24'd0, bus.cpu_cmd}, 32'h09);

        // Randomised traffic.
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 9);
            a1 = {8'($urandom_range(0, 255)), PORT};
            d1 = 8'($urandom_range(0, 255));
            d2 = 8'($urandom_range(0, 255));
            ack_delay = $urandom_range(1, 15);
            ack_hold  = $urandom_range(3, 10);
            case (kind)
                0, 1, 2, 3, 4: begin
                    z80_out(a1, d1, 1'b1);
                    wait_idle();
                end
                5: begin
                    do lo = 8'($urandom_range(0, 255)); while (lo == PORT);
                    z80_out({a1[15:8], lo}, d1, 1'b0);
                    check("rand_wrong_port_cmd", {24'd0, bus.cpu_cmd}, {24'd0, m_last_cmd});
                end
                6: z80_inta(a1);
                7: z80_in(a1, 1'b0);
                8: begin
                    ack_delay = $urandom_range(30, 45);
                    z80_out(a1, d1, 1'b1);
                    z80_out(a1 ^ 16'h0100, d2, 1'b0);
                    m_ovr = 1'b1;
                    check("rand_overrun_cmd", {24'd0, bus.cpu_cmd}, {24'd0, m_last_cmd});
                    wait_idle();
                end
                default: begin
                    do lo = 8'($urandom_range(0, 255)); while (lo == PORT);
                    z80_in({a1[15:8], lo}, 1'b0);
                end
            endcase
        end
        z80_in(16'h00EB, 1'b0);
        repeat (5) @(negedge clk_50);

        check("cmd_queue_drained", cmd_q.size(), 0);
        check("stat_queue_drained", stat_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
